// File: rtl/systolic_matmul_tile_if.sv
// Operand/result handshake bundle for systolic_matmul_tile; the tile sits on the slave side.
// Zero latency (wires only); in_valid/in_ready and out_valid/out_ready carry the flow control.
interface systolic_matmul_tile_if #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32,
    parameter int ROWS   = 8,
    parameter int COLS   = 8,
    parameter int KMAX   = 64
);
    localparam int K_W   = $clog2(KMAX + 1);
    localparam int IDX_W = $clog2(ROWS);

    logic [K_W-1:0]         k_len;
    logic                   accumulate;
    logic                   in_valid;
    logic                   in_ready;
    logic [ROWS*DATA_W-1:0] act_col;
    logic [COLS*DATA_W-1:0] wgt_row;
    logic                   out_valid;
    logic                   out_ready;
    logic [COLS*ACC_W-1:0]  out_row;
    logic [IDX_W-1:0]       out_idx;
    logic                   busy;
    logic                   done;

    modport slave (
        input  k_len, accumulate, in_valid, act_col, wgt_row, out_ready,
        output in_ready, out_valid, out_row, out_idx, busy, done
    );

    modport master (
        output k_len, accumulate, in_valid, act_col, wgt_row, out_ready,
        input  in_ready, out_valid, out_row, out_idx, busy, done
    );
endinterface

// File: rtl/systolic_matmul_tile.sv
// Output-stationary signed ROWSxCOLS matmul tile, runtime K, accumulate mode; SATURATE_EN selects saturating adds.
// Latency: last beat at T -> first result row at T+ROWS+COLS, done at T+2*ROWS+COLS with out_ready held high.
// Backpressure: in_ready only in IDLE/LOAD; DRAIN holds out_row/out_idx while out_ready is low.
module systolic_matmul_tile #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32,
    parameter int ROWS   = 8,
    parameter int COLS   = 8,
    parameter int KMAX   = 64
) (
    input  logic                  clk,
    input  logic                  reset_n,
    systolic_matmul_tile_if.slave io
);
    localparam int K_W    = $clog2(KMAX + 1);
    localparam int IDX_W  = $clog2(ROWS);
    localparam int RC_W   = $clog2(ROWS + COLS);
    localparam int PROD_W = 2 * DATA_W;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    localparam logic [RC_W-1:0] FLUSH_LAST = RC_W'(ROWS + COLS - 2);
    localparam logic [RC_W-1:0] WAVE_DONE  = RC_W'(ROWS + COLS - 1);

    logic [1:0]       r_state;
    logic             r_live;
    logic [K_W-1:0]   r_k;
    logic [K_W-1:0]   r_beat;
    logic [RC_W-1:0]  r_flush;
    logic [RC_W-1:0]  r_wave;
    logic             r_clr;
    logic [IDX_W-1:0] r_idx;
    logic             r_done;

    logic signed [DATA_W-1:0] r_a   [ROWS][COLS];
    logic signed [DATA_W-1:0] r_b   [ROWS][COLS];
    logic signed [ACC_W-1:0]  r_acc [ROWS][COLS];

    logic                     w_beat;
    logic                     w_shift;
    logic                     w_clr;
    logic [K_W-1:0]           w_k_eff;
    logic signed [DATA_W-1:0] w_act  [ROWS];
    logic signed [DATA_W-1:0] w_wgt  [COLS];
    logic signed [DATA_W-1:0] w_a_in [ROWS];
    logic signed [DATA_W-1:0] w_b_in [COLS];

    function automatic logic signed [ACC_W-1:0] f_mac(
        input logic signed [ACC_W-1:0]  base,
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b
    );
        logic signed [PROD_W-1:0] prod;
        logic signed [ACC_W:0]    sum;
        prod = a * b;
        sum  = $signed({base[ACC_W-1], base})
             + $signed({{(ACC_W + 1 - PROD_W){prod[PROD_W-1]}}, prod});
`ifdef SATURATE_EN
        if (sum[ACC_W] != sum[ACC_W-1])
            f_mac = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        else
            f_mac = sum[ACC_W-1:0];
`else
        f_mac = sum[ACC_W-1:0];
`endif
    endfunction

    assign w_beat  = io.in_valid & io.in_ready;
    assign w_shift = w_beat | (r_state == S_LOAD) | (r_state == S_FLUSH);
    assign w_clr   = r_clr & ((r_state == S_LOAD) | (r_state == S_FLUSH));

    always_comb begin
        if (io.k_len == '0)
            w_k_eff = K_W'(1);
        else if (io.k_len > K_W'(KMAX))
            w_k_eff = K_W'(KMAX);
        else
            w_k_eff = io.k_len;
    end

    // Bubbles and idle cycles feed zeros so they contribute nothing to the sums.
    always_comb begin
        for (int i = 0; i < ROWS; i++)
            w_act[i] = w_beat ? $signed(io.act_col[i*DATA_W +: DATA_W]) : '0;
        for (int j = 0; j < COLS; j++)
            w_wgt[j] = w_beat ? $signed(io.wgt_row[j*DATA_W +: DATA_W]) : '0;
    end

    for (genvar gi = 0; gi < ROWS; gi++) begin : g_askew
        if (gi == 0) begin : g_nodly
            assign w_a_in[gi] = w_act[gi];
        end else begin : g_dly
            logic signed [DATA_W-1:0] r_sk [gi];
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    for (int s = 0; s < gi; s++) r_sk[s] <= '0;
                end else if (w_shift) begin
                    r_sk[0] <= w_act[gi];
                    for (int s = 1; s < gi; s++) r_sk[s] <= r_sk[s-1];
                end
            end
            assign w_a_in[gi] = r_sk[gi-1];
        end
    end

    for (genvar gj = 0; gj < COLS; gj++) begin : g_bskew
        if (gj == 0) begin : g_nodly
            assign w_b_in[gj] = w_wgt[gj];
        end else begin : g_dly
            logic signed [DATA_W-1:0] r_sk [gj];
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    for (int s = 0; s < gj; s++) r_sk[s] <= '0;
                end else if (w_shift) begin
                    r_sk[0] <= w_wgt[gj];
                    for (int s = 1; s < gj; s++) r_sk[s] <= r_sk[s-1];
                end
            end
            assign w_b_in[gj] = r_sk[gj-1];
        end
    end

    // PE(i,j) sees the first beat when the wavefront counter equals i+j; a clearing pass overwrites there.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < ROWS; i++) begin
                for (int j = 0; j < COLS; j++) begin
                    r_a[i][j]   <= '0;
                    r_b[i][j]   <= '0;
                    r_acc[i][j] <= '0;
                end
            end
        end else if (w_shift) begin
            for (int i = 0; i < ROWS; i++) begin
                r_a[i][0] <= w_a_in[i];
                for (int j = 1; j < COLS; j++) r_a[i][j] <= r_a[i][j-1];
            end
            for (int j = 0; j < COLS; j++) begin
                r_b[0][j] <= w_b_in[j];
                for (int i = 1; i < ROWS; i++) r_b[i][j] <= r_b[i-1][j];
            end
            for (int i = 0; i < ROWS; i++) begin
                for (int j = 0; j < COLS; j++) begin
                    r_acc[i][j] <= f_mac((w_clr && (r_wave == RC_W'(i + j))) ? '0 : r_acc[i][j],
                                         r_a[i][j], r_b[i][j]);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_live  <= 1'b0;
            r_k     <= '0;
            r_beat  <= '0;
            r_flush <= '0;
            r_wave  <= WAVE_DONE;
            r_clr   <= 1'b0;
            r_idx   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_live <= 1'b1;
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_beat) begin
                        r_k     <= w_k_eff;
                        r_beat  <= K_W'(1);
                        r_clr   <= ~io.accumulate;
                        r_wave  <= '0;
                        r_flush <= '0;
                        r_state <= (w_k_eff == K_W'(1)) ? S_FLUSH : S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (r_wave != WAVE_DONE) r_wave <= r_wave + 1'b1;
                    if (w_beat) begin
                        r_beat <= r_beat + 1'b1;
                        if (r_beat + 1'b1 == r_k) r_state <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    if (r_wave != WAVE_DONE) r_wave <= r_wave + 1'b1;
                    if (r_flush == FLUSH_LAST) r_state <= S_DRAIN;
                    else                       r_flush <= r_flush + 1'b1;
                end
                default: begin
                    if (io.out_ready) begin
                        if (r_idx == IDX_W'(ROWS - 1)) begin
                            r_idx   <= '0;
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    always_comb begin
        io.out_row = '0;
        for (int j = 0; j < COLS; j++)
            io.out_row[j*ACC_W +: ACC_W] = r_acc[r_idx][j];
    end

    assign io.in_ready  = r_live & ((r_state == S_IDLE) | (r_state == S_LOAD));
    assign io.out_valid = (r_state == S_DRAIN);
    assign io.out_idx   = r_idx;
    assign io.busy      = (r_state != S_IDLE);
    assign io.done      = r_done;
endmodule
